// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the 5-stage MIPS subset core: opcode
//               and funct codes, ALU control codes, control-word and
//               pipeline-register structs, and the ID-stage control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic       wr_reg;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       jump;
        logic       mem_write;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;        // PC+4 of this instruction
    } ifid_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        ctrl_t       ctrl;
    } idex_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] rd2;
        logic [3:0]  wr;
        logic        wr_reg;
        logic        mem_to_reg;
        logic        reg_dst;
    } exmem_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_out;
        logic [31:0] dout;
        logic        wr_reg;
        logic        mem_to_reg;
        logic        reg_dst;
    } memwb_t;

    // Anything not recognised (including R-type with an unknown funct, and
    // therefore the all-zero word) decodes to an all-zero control word, i.e.
    // a nop that writes nothing and never redirects.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                c.wr_reg  = 1'b1;
                c.reg_dst = 1'b1;
                case (instr[5:0])
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_NOR:  c.alu_op = ALU_NOR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_ADDI: begin
                c.wr_reg  = 1'b1;
                c.alu_src = 1'b1;
                c.alu_op  = ALU_ADD;
            end
            OP_LW: begin
                c.wr_reg     = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu
// Description : 32-bit ALU for the MIPS subset core (and/or/add/sub/slt/nor).
//               Arithmetic wraps modulo 2^32; slt compares signed.
// Ports       : i_alu_op [3:0]  ALU control code
//               i_a, i_b [31:0] operands
//               o_result [31:0] result
//               o_zero          result == 0
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu
    import mips_pkg::*;
(
    input  logic [3:0]  i_alu_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero
);

    logic [31:0] w_result;

    always_comb begin
        w_result = 32'd0;
        case (i_alu_op)
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_ADD: w_result = i_a + i_b;
            ALU_SUB: w_result = i_a - i_b;
            ALU_SLT: w_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_NOR: w_result = ~(i_a | i_b);
            default: w_result = 32'd0;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == 32'd0);

endmodule
`default_nettype wire

// File: rtl/mips_pipeline_core.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipeline_core
// Description : 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS subset core with an
//               internal instruction ROM and data RAM. No forwarding and no
//               load-use interlock; branches/jumps resolve in EX with a
//               two-slot flush.
// Ports       : clk, nrst (async, active-low) are the only inputs.
//               All other ports are observation outputs: instruction, PC+4,
//               register-file, ALU, memory and control values per stage,
//               plus data RAM words 1..3.
// Parameters  : IMEM_WORDS  ROM depth in words (indexed by pc[7:2])
//               DMEM_WORDS  RAM depth in words (indexed by 6-bit daddr)
//               IMEM_DATA   ROM image, word n at bits [32n+31:32n]
// Revision    : 1.0 - initial release
// ============================================================================
module mips_pipeline_core
    import mips_pkg::*;
#(
    parameter int                      IMEM_WORDS = 64,
    parameter int                      DMEM_WORDS = 64,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_DATA = '0
)
(
    input  logic        clk,
    input  logic        nrst,
    output logic [31:0] instr,
    output logic [31:0] IFID_instr,
    output logic [31:0] IDEX_instr,
    output logic [31:0] EXMEM_instr,
    output logic [31:0] MEMWB_instr,
    output logic [5:0]  daddr,
    output logic [31:0] dout,
    output logic [31:0] MEMWB_dout,
    output logic [3:0]  wr,
    output logic [3:0]  EXMEM_wr,
    output logic [31:0] pc,
    output logic [31:0] IFID_pc,
    output logic [31:0] IDEX_pc,
    output logic [31:0] EXMEM_pc,
    output logic [31:0] reg_din,
    output logic [4:0]  reg_raddr1,
    output logic [31:0] reg_dout1,
    output logic [31:0] IDEX_reg_dout1,
    output logic [4:0]  reg_raddr2,
    output logic [31:0] reg_dout2,
    output logic [31:0] IDEX_reg_dout2,
    output logic [31:0] EXMEM_reg_dout2,
    output logic        wr_reg,
    output logic        EXMEM_wr_reg,
    output logic        MEMWB_wr_reg,
    output logic [4:0]  reg_wr_addr,
    output logic [31:0] ALUOut,
    output logic [31:0] EXMEM_ALUOut,
    output logic [31:0] MEMWB_ALUOut,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic [31:0] ALUIn2,
    output logic        MemToReg,
    output logic        EXMEM_MemToReg,
    output logic        MEMWB_MemToReg,
    output logic        RegDst,
    output logic        EXMEM_RegDst,
    output logic        MEMWB_RegDst,
    output logic        PCSrc,
    output logic [31:0] ram1,
    output logic [31:0] ram2,
    output logic [31:0] ram3,
    output logic        Zero,
    output logic        Branch,
    output logic        Jump
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    ifid_t       r_ifid;
    idex_t       r_idex;
    exmem_t      r_exmem;
    memwb_t      r_memwb;
    logic [31:0] r_regs [32];
    logic [31:0] r_dmem [DMEM_WORDS];

    // ------------------------------------------------------------------
    // IF
    // ------------------------------------------------------------------
    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;

    assign w_instr    = IMEM_DATA[{r_pc[7:2], 5'b00000} +: 32];
    assign w_pc_plus4 = r_pc + 32'd4;

    // ------------------------------------------------------------------
    // WB (needed by ID for write-through)
    // ------------------------------------------------------------------
    logic [4:0]  w_wb_addr;
    logic [31:0] w_wb_data;
    logic        w_wb_en;

    assign w_wb_addr = r_memwb.reg_dst ? r_memwb.instr[15:11] : r_memwb.instr[20:16];
    assign w_wb_data = r_memwb.mem_to_reg ? r_memwb.dout : r_memwb.alu_out;
    assign w_wb_en   = r_memwb.wr_reg && (w_wb_addr != 5'd0);

    // ------------------------------------------------------------------
    // ID
    // ------------------------------------------------------------------
    ctrl_t       w_ctrl;
    logic [4:0]  w_raddr1;
    logic [4:0]  w_raddr2;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;

    assign w_ctrl   = decode_ctrl(r_ifid.instr);
    assign w_raddr1 = r_ifid.instr[25:21];
    assign w_raddr2 = r_ifid.instr[20:16];

    // A write-back to the register being read is bypassed so the consumer
    // sees the new value in the same cycle; this is what lets two
    // independent instructions be enough separation between producer and
    // consumer.
    always_comb begin
        w_rdata1 = r_regs[w_raddr1];
        if (w_raddr1 == 5'd0) begin
            w_rdata1 = 32'd0;
        end else if (w_wb_en && (w_wb_addr == w_raddr1)) begin
            w_rdata1 = w_wb_data;
        end
    end

    always_comb begin
        w_rdata2 = r_regs[w_raddr2];
        if (w_raddr2 == 5'd0) begin
            w_rdata2 = 32'd0;
        end else if (w_wb_en && (w_wb_addr == w_raddr2)) begin
            w_rdata2 = w_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // EX
    // ------------------------------------------------------------------
    logic [31:0] w_simm;
    logic [31:0] w_alu_in2;
    logic [31:0] w_alu_out;
    logic        w_zero;
    logic [3:0]  w_wr_be;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic        w_pcsrc;
    logic [31:0] w_next_pc;

    assign w_simm    = {{16{r_idex.instr[15]}}, r_idex.instr[15:0]};
    assign w_alu_in2 = r_idex.ctrl.alu_src ? w_simm : r_idex.rd2;

    mips_alu u_alu (
        .i_alu_op (r_idex.ctrl.alu_op),
        .i_a      (r_idex.rd1),
        .i_b      (w_alu_in2),
        .o_result (w_alu_out),
        .o_zero   (w_zero)
    );

    assign w_wr_be     = r_idex.ctrl.mem_write ? 4'b1111 : 4'b0000;
    assign w_br_target = r_idex.pc + {w_simm[29:0], 2'b00};
    assign w_j_target  = {r_idex.pc[31:28], r_idex.instr[25:0], 2'b00};
    assign w_pcsrc     = r_idex.ctrl.jump | (r_idex.ctrl.branch & w_zero);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_pcsrc) begin
            w_next_pc = r_idex.ctrl.jump ? w_j_target : w_br_target;
        end
    end

    // ------------------------------------------------------------------
    // MEM
    // ------------------------------------------------------------------
    logic [5:0]  w_daddr;
    logic [31:0] w_dout;

    // Only bits [7:2] address the RAM: larger addresses wrap and the byte
    // offset is dropped.
    assign w_daddr = r_exmem.alu_out[7:2];
    assign w_dout  = r_dmem[w_daddr];

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pc    <= 32'd0;
            r_ifid  <= '0;
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else begin
            r_pc <= w_next_pc;

            // A taken redirect in EX squashes the two younger instructions
            // currently in IF and ID.
            if (w_pcsrc) begin
                r_ifid <= '0;
                r_idex <= '0;
            end else begin
                r_ifid.instr <= w_instr;
                r_ifid.pc    <= w_pc_plus4;
                r_idex.instr <= r_ifid.instr;
                r_idex.pc    <= r_ifid.pc;
                r_idex.rd1   <= w_rdata1;
                r_idex.rd2   <= w_rdata2;
                r_idex.ctrl  <= w_ctrl;
            end

            r_exmem.instr      <= r_idex.instr;
            r_exmem.pc         <= r_idex.pc;
            r_exmem.alu_out    <= w_alu_out;
            r_exmem.rd2        <= r_idex.rd2;
            r_exmem.wr         <= w_wr_be;
            r_exmem.wr_reg     <= r_idex.ctrl.wr_reg;
            r_exmem.mem_to_reg <= r_idex.ctrl.mem_to_reg;
            r_exmem.reg_dst    <= r_idex.ctrl.reg_dst;

            r_memwb.instr      <= r_exmem.instr;
            r_memwb.alu_out    <= r_exmem.alu_out;
            r_memwb.dout       <= w_dout;
            r_memwb.wr_reg     <= r_exmem.wr_reg;
            r_memwb.mem_to_reg <= r_exmem.mem_to_reg;
            r_memwb.reg_dst    <= r_exmem.reg_dst;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < 32; k++) begin
                r_regs[k] <= 32'd0;
            end
        end else if (w_wb_en) begin
            r_regs[w_wb_addr] <= w_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Data RAM (byte-enabled write at the end of MEM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < DMEM_WORDS; k++) begin
                r_dmem[k] <= 32'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_exmem.wr[b]) begin
                    r_dmem[w_daddr][8*b +: 8] <= r_exmem.rd2[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Observation outputs
    // ------------------------------------------------------------------
    assign instr           = w_instr;
    assign IFID_instr      = r_ifid.instr;
    assign IDEX_instr      = r_idex.instr;
    assign EXMEM_instr     = r_exmem.instr;
    assign MEMWB_instr     = r_memwb.instr;
    assign daddr           = w_daddr;
    assign dout            = w_dout;
    assign MEMWB_dout      = r_memwb.dout;
    assign wr              = w_wr_be;
    assign EXMEM_wr        = r_exmem.wr;
    assign pc              = r_pc;
    assign IFID_pc         = r_ifid.pc;
    assign IDEX_pc         = r_idex.pc;
    assign EXMEM_pc        = r_exmem.pc;
    assign reg_din         = w_wb_data;
    assign reg_raddr1      = w_raddr1;
    assign reg_dout1       = w_rdata1;
    assign IDEX_reg_dout1  = r_idex.rd1;
    assign reg_raddr2      = w_raddr2;
    assign reg_dout2       = w_rdata2;
    assign IDEX_reg_dout2  = r_idex.rd2;
    assign EXMEM_reg_dout2 = r_exmem.rd2;
    assign wr_reg          = r_idex.ctrl.wr_reg;
    assign EXMEM_wr_reg    = r_exmem.wr_reg;
    assign MEMWB_wr_reg    = r_memwb.wr_reg;
    assign reg_wr_addr     = w_wb_addr;
    assign ALUOut          = w_alu_out;
    assign EXMEM_ALUOut    = r_exmem.alu_out;
    assign MEMWB_ALUOut    = r_memwb.alu_out;
    assign ALUOp           = r_idex.ctrl.alu_op;
    assign ALUSrc          = r_idex.ctrl.alu_src;
    assign ALUIn2          = w_alu_in2;
    assign MemToReg        = r_idex.ctrl.mem_to_reg;
    assign EXMEM_MemToReg  = r_exmem.mem_to_reg;
    assign MEMWB_MemToReg  = r_memwb.mem_to_reg;
    assign RegDst          = r_idex.ctrl.reg_dst;
    assign EXMEM_RegDst    = r_exmem.reg_dst;
    assign MEMWB_RegDst    = r_memwb.reg_dst;
    assign PCSrc           = w_pcsrc;
    assign ram1            = r_dmem[1];
    assign ram2            = r_dmem[2];
    assign ram3            = r_dmem[3];
    assign Zero            = w_zero;
    assign Branch          = r_idex.ctrl.branch;
    assign Jump            = r_idex.ctrl.jump;

endmodule
`default_nettype wire

// File: tb/tb_mips_pipeline_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_pipeline_core
// Description : Self-checking bench for mips_pipeline_core. A fixed program
//               is placed in the ROM; a per-cycle table holds the expected
//               fetch PC, redirect flag and write-back (enable/address/data),
//               with extra hand checks for the store/load and a mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_pipeline_core;

    // Program (word address : instruction)
    //  0 addi $1,$0,5      1-2 nop     3 addi $2,$1,7   4-5 nop
    //  6 sub  $3,$1,$2     7 sw $2,4($0)   8 lw $4,4($0)
    //  9 beq  $1,$1,+2    10-11 addi (must be flushed)
    // 12 j    0x10        13-15 addi (13,14 flushed, 15 never fetched)
    // 16 slt $5,$3,$1  17 and $9,$1,$2  18 or $10,$1,$2  19 nor $11,$1,$2
    // 20 add $12,$4,$2 21 unknown opcode 22 j 0x16 (self loop)
    function automatic logic [2047:0] build_prog();
        logic [2047:0] p;
        p = '0;
        p[32*0  +: 32] = 32'h2001_0005;
        p[32*3  +: 32] = 32'h2022_0007;
        p[32*6  +: 32] = 32'h0022_1822;
        p[32*7  +: 32] = 32'hAC02_0004;
        p[32*8  +: 32] = 32'h8C04_0004;
        p[32*9  +: 32] = 32'h1021_0002;
        p[32*10 +: 32] = 32'h2006_0055;
        p[32*11 +: 32] = 32'h2007_0066;
        p[32*12 +: 32] = 32'h0800_0010;
        p[32*13 +: 32] = 32'h2006_0001;
        p[32*14 +: 32] = 32'h2007_0002;
        p[32*15 +: 32] = 32'h2008_0077;
        p[32*16 +: 32] = 32'h0061_282A;
        p[32*17 +: 32] = 32'h0022_4824;
        p[32*18 +: 32] = 32'h0022_5025;
        p[32*19 +: 32] = 32'h0022_5827;
        p[32*20 +: 32] = 32'h0082_6020;
        p[32*21 +: 32] = 32'hFC00_0000;
        p[32*22 +: 32] = 32'h0800_0016;
        return p;
    endfunction

    localparam logic [2047:0] PROG = build_prog();

    logic        clk;
    logic        nrst;
    logic [31:0] instr, IFID_instr, IDEX_instr, EXMEM_instr, MEMWB_instr;
    logic [5:0]  daddr;
    logic [31:0] dout, MEMWB_dout;
    logic [3:0]  wr, EXMEM_wr;
    logic [31:0] pc, IFID_pc, IDEX_pc, EXMEM_pc;
    logic [31:0] reg_din;
    logic [4:0]  reg_raddr1, reg_raddr2, reg_wr_addr;
    logic [31:0] reg_dout1, IDEX_reg_dout1, reg_dout2, IDEX_reg_dout2, EXMEM_reg_dout2;
    logic        wr_reg, EXMEM_wr_reg, MEMWB_wr_reg;
    logic [31:0] ALUOut, EXMEM_ALUOut, MEMWB_ALUOut, ALUIn2;
    logic [3:0]  ALUOp;
    logic        ALUSrc, MemToReg, EXMEM_MemToReg, MEMWB_MemToReg;
    logic        RegDst, EXMEM_RegDst, MEMWB_RegDst;
    logic        PCSrc, Zero, Branch, Jump;
    logic [31:0] ram1, ram2, ram3;

    mips_pipeline_core #(
        .IMEM_WORDS (64),
        .DMEM_WORDS (64),
        .IMEM_DATA  (PROG)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .instr           (instr),
        .IFID_instr      (IFID_instr),
        .IDEX_instr      (IDEX_instr),
        .EXMEM_instr     (EXMEM_instr),
        .MEMWB_instr     (MEMWB_instr),
        .daddr           (daddr),
        .dout            (dout),
        .MEMWB_dout      (MEMWB_dout),
        .wr              (wr),
        .EXMEM_wr        (EXMEM_wr),
        .pc              (pc),
        .IFID_pc         (IFID_pc),
        .IDEX_pc         (IDEX_pc),
        .EXMEM_pc        (EXMEM_pc),
        .reg_din         (reg_din),
        .reg_raddr1      (reg_raddr1),
        .reg_dout1       (reg_dout1),
        .IDEX_reg_dout1  (IDEX_reg_dout1),
        .reg_raddr2      (reg_raddr2),
        .reg_dout2       (reg_dout2),
        .IDEX_reg_dout2  (IDEX_reg_dout2),
        .EXMEM_reg_dout2 (EXMEM_reg_dout2),
        .wr_reg          (wr_reg),
        .EXMEM_wr_reg    (EXMEM_wr_reg),
        .MEMWB_wr_reg    (MEMWB_wr_reg),
        .reg_wr_addr     (reg_wr_addr),
        .ALUOut          (ALUOut),
        .EXMEM_ALUOut    (EXMEM_ALUOut),
        .MEMWB_ALUOut    (MEMWB_ALUOut),
        .ALUOp           (ALUOp),
        .ALUSrc          (ALUSrc),
        .ALUIn2          (ALUIn2),
        .MemToReg        (MemToReg),
        .EXMEM_MemToReg  (EXMEM_MemToReg),
        .MEMWB_MemToReg  (MEMWB_MemToReg),
        .RegDst          (RegDst),
        .EXMEM_RegDst    (EXMEM_RegDst),
        .MEMWB_RegDst    (MEMWB_RegDst),
        .PCSrc           (PCSrc),
        .ram1            (ram1),
        .ram2            (ram2),
        .ram3            (ram3),
        .Zero            (Zero),
        .Branch          (Branch),
        .Jump            (Jump)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic        pcsrc;
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    localparam int NV = 28;
    vec_t vec [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input int i);
        chk($sformatf("pc[c%0d]", i), pc, vec[i].pc);
        chk($sformatf("PCSrc[c%0d]", i), 32'(PCSrc), 32'(vec[i].pcsrc));
        chk($sformatf("MEMWB_wr_reg[c%0d]", i), 32'(MEMWB_wr_reg), 32'(vec[i].wr));
        if (vec[i].wr) begin
            chk($sformatf("reg_wr_addr[c%0d]", i), 32'(reg_wr_addr), 32'(vec[i].waddr));
            chk($sformatf("reg_din[c%0d]", i), reg_din, vec[i].wdata);
        end
        case (i)
            8: chk("ALUOut sub", ALUOut, 32'hFFFF_FFF9);
            9: chk("wr sw", 32'(wr), 32'h0000_000F);
            10: begin
                chk("EXMEM_wr sw", 32'(EXMEM_wr), 32'h0000_000F);
                chk("daddr sw", 32'(daddr), 32'd1);
                chk("EXMEM_reg_dout2 sw", EXMEM_reg_dout2, 32'd12);
                chk("ram1 before store", ram1, 32'd0);
            end
            11: begin
                chk("ram1 after store", ram1, 32'd12);
                chk("dout lw", dout, 32'd12);
                chk("Zero beq", 32'(Zero), 32'd1);
            end
            12: begin
                chk("MEMWB_dout lw", MEMWB_dout, 32'd12);
                chk("MEMWB_MemToReg lw", 32'(MEMWB_MemToReg), 32'd1);
            end
            default: ;
        endcase
    endtask

    initial begin
        //            pc            pcsrc wr    waddr  wdata
        vec[0]  = '{32'd0,  1'b0, 1'b0, 5'd0,  32'd0};
        vec[1]  = '{32'd4,  1'b0, 1'b0, 5'd0,  32'd0};
        vec[2]  = '{32'd8,  1'b0, 1'b0, 5'd0,  32'd0};
        vec[3]  = '{32'd12, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[4]  = '{32'd16, 1'b0, 1'b1, 5'd1,  32'd5};
        vec[5]  = '{32'd20, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[6]  = '{32'd24, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[7]  = '{32'd28, 1'b0, 1'b1, 5'd2,  32'd12};
        vec[8]  = '{32'd32, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[9]  = '{32'd36, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[10] = '{32'd40, 1'b0, 1'b1, 5'd3,  32'hFFFF_FFF9};
        vec[11] = '{32'd44, 1'b1, 1'b0, 5'd0,  32'd0};
        vec[12] = '{32'd48, 1'b0, 1'b1, 5'd4,  32'd12};
        vec[13] = '{32'd52, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[14] = '{32'd56, 1'b1, 1'b0, 5'd0,  32'd0};
        vec[15] = '{32'd64, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[16] = '{32'd68, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[17] = '{32'd72, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[18] = '{32'd76, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[19] = '{32'd80, 1'b0, 1'b1, 5'd5,  32'd1};
        vec[20] = '{32'd84, 1'b0, 1'b1, 5'd9,  32'd4};
        vec[21] = '{32'd88, 1'b0, 1'b1, 5'd10, 32'd13};
        vec[22] = '{32'd92, 1'b0, 1'b1, 5'd11, 32'hFFFF_FFF2};
        vec[23] = '{32'd96, 1'b1, 1'b1, 5'd12, 32'd24};
        vec[24] = '{32'd88, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[25] = '{32'd92, 1'b0, 1'b0, 5'd0,  32'd0};
        vec[26] = '{32'd96, 1'b1, 1'b0, 5'd0,  32'd0};
        vec[27] = '{32'd88, 1'b0, 1'b0, 5'd0,  32'd0};

        // Reset held for 75 ns; observe state inside the reset window.
        nrst = 1'b0;
        @(negedge clk);
        chk("rst pc", pc, 32'd0);
        chk("rst instr", instr, 32'h2001_0005);
        chk("rst IFID_instr", IFID_instr, 32'd0);
        chk("rst IDEX_instr", IDEX_instr, 32'd0);
        chk("rst EXMEM_instr", EXMEM_instr, 32'd0);
        chk("rst MEMWB_instr", MEMWB_instr, 32'd0);
        chk("rst MEMWB_wr_reg", 32'(MEMWB_wr_reg), 32'd0);
        chk("rst EXMEM_wr", 32'(EXMEM_wr), 32'd0);
        chk("rst PCSrc", 32'(PCSrc), 32'd0);
        chk("rst reg_din", reg_din, 32'd0);
        chk("rst ALUOut", ALUOut, 32'd0);
        chk("rst ram1", ram1, 32'd0);
        #35 nrst = 1'b1;

        // Main program run, one table row per cycle.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check_cycle(i);
        end

        // Asynchronous reset in the middle of a clock phase.
        #5 nrst = 1'b0;
        #1;
        chk("midrst pc", pc, 32'd0);
        chk("midrst IFID_instr", IFID_instr, 32'd0);
        chk("midrst IDEX_instr", IDEX_instr, 32'd0);
        chk("midrst EXMEM_instr", EXMEM_instr, 32'd0);
        chk("midrst MEMWB_wr_reg", 32'(MEMWB_wr_reg), 32'd0);
        chk("midrst ram1", ram1, 32'd0);
        @(negedge clk);
        chk("midrst held pc", pc, 32'd0);
        #10 nrst = 1'b1;

        // The first posedge after release advances to the equivalent of
        // table row 1; replay rows 1..12 (covers store/load on cleared RAM).
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check_cycle(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
